// File: rtl/cla_add_sequencer.sv
// Multi-cycle wide adder/subtractor built around one 8-bit CLA slice.
// Operands are latched on start and processed one byte per clock, LSB first.
module cla_add_sequencer #(
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 sub,
   input  logic                 cin,
   input  logic [8*WORDS-1:0]   a,
   input  logic [8*WORDS-1:0]   b,
   output logic                 busy,
   output logic                 done,
   output logic [8*WORDS-1:0]   sum,
   output logic                 cout,
   output logic                 ovf
);

   localparam int W  = 8 * WORDS;
   localparam int IW = $clog2(WORDS);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [IW-1:0] idx;
   logic          carry;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;

   logic [7:0]    sa;
   logic [7:0]    sb;
   logic [7:0]    p;
   logic [7:0]    g;
   logic [7:0]    c;
   logic [7:0]    s;
   logic          accept;
   logic          last;

   // A new request is taken in IDLE, and in DONE for back-to-back issue.
   assign accept = start && (state == IDLE || state == DONE);
   assign last   = (idx == IW'(WORDS - 1));

   // Status flags decode straight from the state register.
   assign busy = (state == RUN);
   assign done = (state == DONE);

   // Select the current byte slice and form propagate/generate.
   always_comb begin
      sa = a_q[8*idx +: 8];
      sb = b_q[8*idx +: 8];
      p  = sa ^ sb;
      g  = sa & sb;
   end

   // Lookahead carries: c[i] = G[i:0] | P[i:0] & carry, fully flattened.
   always_comb begin
      logic term;
      c    = '0;
      term = 1'b0;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) begin
               term = term & p[k];
            end
            c[i] = c[i] | term;
         end
         term = carry;
         for (int k = 0; k <= i; k++) begin
            term = term & p[k];
         end
         c[i] = c[i] | term;
      end
      s = p ^ {c[6:0], carry};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = DONE;
         DONE:    state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand latches, slice walk, carry chain and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx   <= '0;
         carry <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b ^ {W{sub}};
         carry <= sub | cin;
         idx   <= '0;
      end else if (state == RUN) begin
         sum[8*idx +: 8] <= s;
         carry           <= c[7];
         if (last) begin
            cout <= c[7];
            ovf  <= c[7] ^ c[6];
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Directed self-checking bench for cla_add_sequencer (WORDS=4).
// Inputs are driven and outputs sampled on the falling edge.
module tb_cla_add_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic        sub;
   logic        cin;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;

   int total;
   int passed;

   cla_add_sequencer #(.WORDS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .sub   (sub),
      .cin   (cin),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic flags(input string tag, input logic eb, input logic ed);
      chk({tag, " busy"}, 64'(busy), 64'(eb));
      chk({tag, " done"}, 64'(done), 64'(ed));
   endtask

   task automatic result(input string tag, input logic [31:0] es,
                         input logic ec, input logic eo);
      chk({tag, " sum"},  64'(sum),  64'(es));
      chk({tag, " cout"}, 64'(cout), 64'(ec));
      chk({tag, " ovf"},  64'(ovf),  64'(eo));
   endtask

   // One full operation; inputs are scrambled after acceptance.
   task automatic do_op(input string tag, input logic [31:0] ta,
                        input logic [31:0] tb, input logic ts,
                        input logic tc, input logic [31:0] es,
                        input logic ec, input logic eo);
      @(negedge clk);
      a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = ~ta; b = ~tb; sub = ~ts; cin = ~tc;
      flags({tag, " c1"}, 1'b1, 1'b0);
      for (int k = 2; k <= 4; k++) begin
         @(negedge clk);
         flags($sformatf("%s c%0d", tag, k), 1'b1, 1'b0);
      end
      @(negedge clk);
      flags({tag, " c5"}, 1'b0, 1'b1);
      result(tag, es, ec, eo);
      @(negedge clk);
      flags({tag, " c6"}, 1'b0, 1'b0);
      result({tag, " hold"}, es, ec, eo);
   endtask

   initial begin
      total = 0;
      passed = 0;
      reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0;
      a = '0; b = '0;
      repeat (2) @(negedge clk);
      flags("reset", 1'b0, 1'b0);
      result("reset", 32'h0, 1'b0, 1'b0);
      reset = 1'b0;

      do_op("ff+1", 32'h000000FF, 32'h00000001, 1'b0, 1'b0,
            32'h00000100, 1'b0, 1'b0);
      do_op("wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0,
            32'h00000000, 1'b1, 1'b0);
      do_op("povf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0,
            32'h80000000, 1'b0, 1'b1);
      do_op("sub5-7", 32'h00000005, 32'h00000007, 1'b1, 1'b1,
            32'hFFFFFFFE, 1'b0, 1'b0);
      do_op("subovf", 32'h80000000, 32'h00000001, 1'b1, 1'b0,
            32'h7FFFFFFF, 1'b1, 1'b1);

      // Reset in cycle 2 of an operation aborts it.
      @(negedge clk);
      a = 32'h12345678; b = 32'h11111111; sub = 1'b0; cin = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flags("abort c1", 1'b1, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      flags("abort c3", 1'b0, 1'b0);
      result("abort c3", 32'h0, 1'b0, 1'b0);
      for (int k = 4; k <= 8; k++) begin
         @(negedge clk);
         flags($sformatf("abort c%0d", k), 1'b0, 1'b0);
      end
      do_op("afterabort", 32'h00010203, 32'h00F0F0F0, 1'b0, 1'b1,
            32'h00F1F2F4, 1'b0, 1'b0);

      // Extra start pulses in cycles 2 and 3 must be ignored.
      @(negedge clk);
      a = 32'h12345678; b = 32'h11111111; sub = 1'b0; cin = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flags("ign c1", 1'b1, 1'b0);
      @(negedge clk);
      flags("ign c2", 1'b1, 1'b0);
      a = 32'hAAAAAAAA; b = 32'h55555555; sub = 1'b1; start = 1'b1;
      @(negedge clk);
      flags("ign c3", 1'b1, 1'b0);
      a = 32'h00000001; b = 32'hFFFFFFFF; sub = 1'b0; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flags("ign c4", 1'b1, 1'b0);
      @(negedge clk);
      flags("ign c5", 1'b0, 1'b1);
      result("ign", 32'h23456789, 1'b0, 1'b0);
      @(negedge clk);
      flags("ign c6", 1'b0, 1'b0);
      @(negedge clk);
      flags("ign c7", 1'b0, 1'b0);

      // start held high: accepted in cycle 0 and again in DONE.
      a = 32'h12345678; b = 32'h11111111; sub = 1'b0; cin = 1'b0;
      start = 1'b1;
      @(negedge clk);
      a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1;
      flags("held c1", 1'b1, 1'b0);
      for (int k = 2; k <= 4; k++) begin
         @(negedge clk);
         flags($sformatf("held c%0d", k), 1'b1, 1'b0);
      end
      @(negedge clk);
      flags("held c5", 1'b0, 1'b1);
      result("held op1", 32'h23456789, 1'b0, 1'b0);
      for (int k = 6; k <= 9; k++) begin
         @(negedge clk);
         flags($sformatf("held c%0d", k), 1'b1, 1'b0);
      end
      @(negedge clk);
      start = 1'b0;
      flags("held c10", 1'b0, 1'b1);
      result("held op2", 32'hFFFFFFFF, 1'b1, 1'b0);
      @(negedge clk);
      flags("held c11", 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
